kyber_ntt_core: RTL and testbench

Forward Kyber NTT engine, q = 3329, 256 coefficients, in place, one Cooley-Tukey butterfly issued per clock.
It is the direct consumer of the 256x12 zeta pROM dist_mem_gen_0, which holds 17^i mod 3329 in natural order i = 0..255. It drives the ROM address, ce and oce pins and takes zetas from the ROM dout.
Coefficients live in an external 256x12 RAM with two synchronous read ports and two write ports; this block sequences all 7 layers and then signals done.

---
 rtl/kyber_pkg.sv | 35 +++
 rtl/kyber_ntt_core_if.sv | 41 ++++
 rtl/kyber_modmul.sv | 38 +++
 rtl/kyber_ntt_core.sv | 181 ++++++++++++++++++
 tb/tb_kyber_ntt_core.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and helpers for the Kyber forward NTT engine.
package kyber_pkg;

    localparam int unsigned Q        = 3329;
    localparam int unsigned DW       = 12;
    localparam int unsigned AW       = 8;
    localparam int unsigned PIPE_LAT = 4;

    localparam int unsigned NUM_LAYERS = 7;
    localparam int unsigned BFLY_PER_LAYER = 128;

    // Barrett constant floor(2^24 / Q); every 12x12 product is below 2^24, so the
    // estimated quotient is at most one short and a single subtract finishes the job.
    localparam int unsigned BARRETT_SHIFT = 24;
    localparam int unsigned BARRETT_M     = 5039;

    // Modulus at the width of an unreduced sum/difference.
    localparam logic [DW:0] QX = (DW + 1)'(Q);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFin
    } ntt_state_e;

    function automatic logic [6:0] bitrev7(input logic [6:0] x);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) begin
            r[i] = x[6 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/kyber_ntt_core_if.sv
// Start/status handshake plus zeta ROM and coefficient RAM ports of the NTT engine.
// master: the NTT core. slave: the surrounding system (controller, ROM, RAM).
interface kyber_ntt_core_if;
    import kyber_pkg::*;

    logic          start;
    logic          busy;
    logic          done;

    logic [AW-1:0] rom_ad;
    logic          rom_ce;
    logic          rom_oce;
    logic [DW-1:0] rom_dout;

    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;

    logic          wr_en;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;
    logic [DW-1:0] wr_data_a;
    logic [DW-1:0] wr_data_b;

    modport master (
        input  start, rom_dout, rd_data_a, rd_data_b,
        output busy, done, rom_ad, rom_ce, rom_oce,
        output rd_en, rd_addr_a, rd_addr_b,
        output wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
    );

    modport slave (
        output start, rom_dout, rd_data_a, rd_data_b,
        input  busy, done, rom_ad, rom_ce, rom_oce,
        input  rd_en, rd_addr_a, rd_addr_b,
        input  wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
    );

endinterface

// File: rtl/kyber_modmul.sv
// Two-stage (a * b) mod Q: registered product, then Barrett reduction registered.
module kyber_modmul
    import kyber_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] r
);

    logic [2*DW-1:0] prod_q;
    logic [DW-1:0]   r_q;
    logic [DW:0]     quo;
    logic [DW:0]     rem;
    logic [DW-1:0]   r_d;

    // Barrett reduction of the registered product; rem lands in [0, 2Q).
    always_comb begin
        quo = (DW + 1)'((37'(prod_q) * 37'(BARRETT_M)) >> BARRETT_SHIFT);
        rem = (DW + 1)'(25'(prod_q) - 25'(quo) * 25'(Q));
        r_d = DW'((rem >= QX) ? rem - QX : rem);
    end

    // Multiply stage then reduce stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            r_q    <= '0;
        end else begin
            prod_q <= (2 * DW)'(a) * (2 * DW)'(b);
            r_q    <= r_d;
        end
    end

    assign r = r_q;

endmodule

// File: rtl/kyber_ntt_core.sv
// Forward Kyber NTT sequencer: one butterfly per clock, 7 layers, drain between layers.
module kyber_ntt_core
    import kyber_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    kyber_ntt_core_if.master bus
);

    localparam int unsigned       DRAIN_W    = $clog2(PIPE_LAT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [2:0]         LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [6:0]         LAST_BFLY  = 7'(BFLY_PER_LAYER - 1);

    ntt_state_e         state_q, state_d;
    logic [2:0]         layer_q, layer_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic          issue;
    logic [AW-1:0] len;
    logic [AW-1:0] lo_mask;
    logic [AW-1:0] cnt8;
    logic [AW-1:0] j_idx;
    logic [6:0]    k_idx;

    // Pipeline: s1 = RAM/ROM data, s2 = product reg, s3 = reduced reg, then write.
    logic          v1_q, v2_q, v3_q;
    logic [AW-1:0] adr_a1_q, adr_b1_q, adr_a2_q, adr_b2_q, adr_a3_q, adr_b3_q;
    logic [DW-1:0] a2_q, a3_q;
    logic [DW-1:0] t_mm;

    logic          wr_en_q;
    logic [AW-1:0] wr_addr_a_q, wr_addr_b_q;
    logic [DW-1:0] wr_data_a_q, wr_data_b_q;
    logic [DW:0]   sum, dif;
    logic [DW-1:0] sum_red, dif_red;

    // Sequencer state and loop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            layer_q <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    // Next state: 128 issues per layer, PIPE_LAT drain cycles, then next layer or finish.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StIssue;
                    layer_d = '0;
                    cnt_d   = '0;
                    drain_d = '0;
                end
            end
            StIssue: begin
                // Wraps to zero after the layer's last butterfly.
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LAST_BFLY) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    if (layer_q == LAST_LAYER) begin
                        state_d = StFin;
                    end else begin
                        state_d = StIssue;
                        layer_d = layer_q + 3'd1;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Butterfly index -> j and zeta index k. len is a power of two, so the group
    // number is cnt / len and j inserts a zero bit at position log2(len).
    always_comb begin
        issue   = (state_q == StIssue);
        len     = 8'd128 >> layer_q;
        lo_mask = len - 8'd1;
        cnt8    = {1'b0, cnt_q};
        j_idx   = ((cnt8 & ~lo_mask) << 1) | (cnt8 & lo_mask);
        k_idx   = 7'((8'd1 << layer_q) + (cnt8 >> (3'd7 - layer_q)));
    end

    assign bus.busy      = (state_q == StIssue) || (state_q == StDrain);
    assign bus.done      = (state_q == StFin);
    assign bus.rd_en     = issue;
    assign bus.rom_ce    = issue;
    assign bus.rom_oce   = issue;
    assign bus.rd_addr_a = issue ? j_idx : '0;
    assign bus.rd_addr_b = issue ? j_idx + len : '0;
    assign bus.rom_ad    = issue ? {1'b0, bitrev7(k_idx)} : '0;

    kyber_modmul u_modmul (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (bus.rom_dout),
        .b     (bus.rd_data_b),
        .r     (t_mm)
    );

    // Addresses, valid and the a operand follow the modmul latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            adr_a1_q <= '0;
            adr_b1_q <= '0;
            adr_a2_q <= '0;
            adr_b2_q <= '0;
            adr_a3_q <= '0;
            adr_b3_q <= '0;
            a2_q     <= '0;
            a3_q     <= '0;
        end else begin
            v1_q     <= issue;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            adr_a1_q <= bus.rd_addr_a;
            adr_b1_q <= bus.rd_addr_b;
            adr_a2_q <= adr_a1_q;
            adr_b2_q <= adr_b1_q;
            adr_a3_q <= adr_a2_q;
            adr_b3_q <= adr_b2_q;
            a2_q     <= bus.rd_data_a;
            a3_q     <= a2_q;
        end
    end

    // Modular add/sub; inputs canonical, so one conditional subtract suffices.
    always_comb begin
        sum     = (DW + 1)'(a3_q) + (DW + 1)'(t_mm);
        dif     = (DW + 1)'(a3_q) + QX - (DW + 1)'(t_mm);
        sum_red = DW'((sum >= QX) ? sum - QX : sum);
        dif_red = DW'((dif >= QX) ? dif - QX : dif);
    end

    // Registered write-back port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            wr_data_a_q <= '0;
            wr_data_b_q <= '0;
        end else begin
            wr_en_q     <= v3_q;
            wr_addr_a_q <= adr_a3_q;
            wr_addr_b_q <= adr_b3_q;
            wr_data_a_q <= sum_red;
            wr_data_b_q <= dif_red;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr_a = wr_addr_a_q;
    assign bus.wr_addr_b = wr_addr_b_q;
    assign bus.wr_data_a = wr_data_a_q;
    assign bus.wr_data_b = wr_data_b_q;

endmodule

// File: tb/tb_kyber_ntt_core.sv
// Self-checking bench for kyber_ntt_core: ROM/RAM models plus a software NTT reference.
module tb_kyber_ntt_core;

    localparam int QM = 3329;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kyber_ntt_core_if bus();

    kyber_ntt_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [11:0] ram [256];
    logic [11:0] rom [256];
    int          ref_a [256];

    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [11:0] ld_data = '0;

    int n_checks = 0;
    int n_errs = 0;

    // Zeta ROM and dual-port coefficient RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rom_ce) bus.rom_dout <= rom[bus.rom_ad];
        if (bus.rd_en) begin
            bus.rd_data_a <= ram[bus.rd_addr_a];
            bus.rd_data_b <= ram[bus.rd_addr_b];
        end
        if (bus.wr_en) begin
            ram[bus.wr_addr_a] <= bus.wr_data_a;
            ram[bus.wr_addr_b] <= bus.wr_data_b;
        end
        if (ld_en) ram[ld_addr] <= ld_data;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int brv7(input int k);
        int r = 0;
        for (int i = 0; i < 7; i++) if ((k >> i) & 1) r |= 1 << (6 - i);
        return r;
    endfunction

    function automatic int zeta_of(input int k);
        int p = 1;
        for (int i = 0; i < brv7(k); i++) p = (p * 17) % QM;
        return p;
    endfunction

    // Textbook Kyber forward NTT, normal domain, on ref_a.
    task automatic model_ntt();
        int k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                int z = zeta_of(k);
                k++;
                for (int j = st; j < st + len; j++) begin
                    int t = (z * ref_a[j + len]) % QM;
                    ref_a[j + len] = (ref_a[j] - t + QM) % QM;
                    ref_a[j] = (ref_a[j] + t) % QM;
                end
            end
        end
    endtask

    task automatic load_ram();
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            ld_en = 1'b1;
            ld_addr = 8'(i);
            ld_data = 12'(ref_a[i]);
            @(negedge clk);
        end
        ld_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic compare_ram(input string tag);
        for (int i = 0; i < 256; i++) check_eq($sformatf("%s[%0d]", tag, i), int'(ram[i]), ref_a[i]);
    endtask

    // Run observation statistics
    int start_sched[$];
    int done_cyc[$];
    int rise_cyc[$];
    int wr_cnt, busy_cnt, last_issue, bad_range;
    int fw_seen, fw_cyc, fw_aa, fw_ab, fw_da, fw_db;
    int fi_seen, fi_rom_ad;

    function automatic bit in_sched(input int c);
        foreach (start_sched[i]) if (start_sched[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Drives start per start_sched; cycle 0 is the cycle whose closing edge samples start.
    task automatic run_sched(input int max_cyc, input int rst_cyc);
        bit prev_rd = 1'b0;
        done_cyc.delete();
        rise_cyc.delete();
        wr_cnt = 0; busy_cnt = 0; last_issue = -1; bad_range = 0;
        fw_seen = 0; fi_seen = 0;
        fw_cyc = -1; fw_aa = -1; fw_ab = -1; fw_da = -1; fw_db = -1; fi_rom_ad = -1;
        @(negedge clk);
        for (int c = 0; c < max_cyc; c++) begin
            if (bus.wr_en) begin
                wr_cnt++;
                if (bus.wr_data_a >= 12'(QM) || bus.wr_data_b >= 12'(QM)) bad_range++;
                if (fw_seen == 0) begin
                    fw_seen = 1; fw_cyc = c;
                    fw_aa = bus.wr_addr_a; fw_ab = bus.wr_addr_b;
                    fw_da = bus.wr_data_a; fw_db = bus.wr_data_b;
                end
            end
            if (bus.rd_en && fi_seen == 0) begin
                fi_seen = 1;
                fi_rom_ad = bus.rom_ad;
            end
            if (bus.rd_en && !prev_rd) rise_cyc.push_back(c);
            if (bus.rd_en) last_issue = c;
            prev_rd = bus.rd_en;
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cyc.push_back(c);
            if (c == rst_cyc) begin
                check_eq("pre_rst_rd_en", int'(bus.rd_en), 1);
                rst_n = 1'b0;
                #1;
                check_eq("rst_busy", int'(bus.busy), 0);
                check_eq("rst_wr_en", int'(bus.wr_en), 0);
                check_eq("rst_rd_en", int'(bus.rd_en), 0);
                prev_rd = 1'b0;
            end
            if (c == rst_cyc + 2) rst_n = 1'b1;
            bus.start = in_sched(c);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_single_run(input string tag);
        check_eq({tag, "_done_count"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) check_eq({tag, "_done_cycle"}, done_cyc[0], 925);
        check_eq({tag, "_wr_count"}, wr_cnt, 896);
        check_eq({tag, "_range_viol"}, bad_range, 0);
    endtask

    initial begin
        int p = 1;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 12'(p);
            p = (p * 17) % QM;
        end
        bus.start = 1'b0;
        bus.rom_dout = '0;
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", int'(bus.busy), 0);
        check_eq("reset_done", int'(bus.done), 0);
        check_eq("reset_rd_en", int'(bus.rd_en), 0);
        check_eq("reset_wr_en", int'(bus.wr_en), 0);
        check_eq("reset_rom_ce", int'(bus.rom_ce), 0);
        check_eq("reset_rom_oce", int'(bus.rom_oce), 0);
        check_eq("reset_rom_ad", int'(bus.rom_ad), 0);
        check_eq("reset_rd_addr_b", int'(bus.rd_addr_b), 0);
        check_eq("reset_wr_addr_b", int'(bus.wr_addr_b), 0);
        check_eq("reset_wr_data_a", int'(bus.wr_data_a), 0);
        rst_n = 1'b1;
        start_sched = '{0};

        // Impulse at a[0]: every output is 1; also timing of the whole schedule
        foreach (ref_a[i]) ref_a[i] = 0;
        ref_a[0] = 1;
        load_ram();
        model_ntt();
        run_sched(1000, -1);
        compare_ram("impulse0");
        check_single_run("impulse0");
        check_eq("busy_cycles", busy_cnt, 924);
        check_eq("last_issue", last_issue, 920);
        check_eq("layer_rises", rise_cyc.size(), 7);
        for (int l = 0; l < 7 && l < rise_cyc.size(); l++)
            check_eq($sformatf("layer%0d_first_issue", l), rise_cyc[l], 1 + 132 * l);

        // Impulse at a[128]: first butterfly uses zeta 17^64 = 1729
        foreach (ref_a[i]) ref_a[i] = 0;
        ref_a[128] = 1;
        load_ram();
        model_ntt();
        run_sched(1000, -1);
        check_eq("first_rom_ad", fi_rom_ad, 'h40);
        check_eq("first_wr_cycle", fw_cyc, 5);
        check_eq("first_wr_addr_a", fw_aa, 0);
        check_eq("first_wr_addr_b", fw_ab, 128);
        check_eq("first_wr_data_a", fw_da, 1729);
        check_eq("first_wr_data_b", fw_db, 1600);
        compare_ram("impulse128");
        check_single_run("impulse128");

        // Random, all-max and all-zero vectors
        for (int v = 0; v < 4; v++) begin
            foreach (ref_a[i]) begin
                if (v < 2) ref_a[i] = int'($urandom_range(0, QM - 1));
                else if (v == 2) ref_a[i] = QM - 1;
                else ref_a[i] = 0;
            end
            load_ram();
            model_ntt();
            run_sched(1000, -1);
            compare_ram($sformatf("vec%0d", v));
            check_single_run($sformatf("vec%0d", v));
        end

        // Starts while busy and with done are ignored; start right after done runs again
        foreach (ref_a[i]) ref_a[i] = int'($urandom_range(0, QM - 1));
        load_ram();
        model_ntt();
        model_ntt();
        start_sched = '{0, 10, 925, 926};
        run_sched(1900, -1);
        check_eq("restart_done_count", done_cyc.size(), 2);
        if (done_cyc.size() > 1) begin
            check_eq("restart_done0", done_cyc[0], 925);
            check_eq("restart_done1", done_cyc[1], 926 + 925);
        end
        check_eq("restart_wr_count", wr_cnt, 2 * 896);
        compare_ram("double_ntt");

        // Reset mid-run aborts without done; a reload and restart is correct
        start_sched = '{0};
        foreach (ref_a[i]) ref_a[i] = int'($urandom_range(0, QM - 1));
        load_ram();
        run_sched(1300, 300);
        check_eq("abort_done_count", done_cyc.size(), 0);
        foreach (ref_a[i]) ref_a[i] = int'($urandom_range(0, QM - 1));
        load_ram();
        model_ntt();
        run_sched(1000, -1);
        compare_ram("after_abort");
        check_single_run("after_abort");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
